// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel word to MSB-first serial transmitter with idle gap and abort
module serial_word_tx #(
  parameter int   WIDTH      = 12,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             in_ready,
  output logic             x,
  output logic             frame,
  output logic             done,
  output logic [3:0]       bit_idx,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);
  // Clamped so a zero gap does not produce a negative compare value.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t           st;
  logic [WIDTH-1:0] shreg;
  logic [3:0]       gap_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st      <= S_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (st == S_SHIFT || st == S_GAP)) begin
        st      <= S_IDLE;
        bit_idx <= '0;
        gap_cnt <= '0;
      end else begin
        case (st)
          S_IDLE: begin
            if (in_valid) begin
              shreg   <= in_data;
              bit_idx <= '0;
              st      <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (bit_idx == LAST_IDX) begin
              done    <= 1'b1;
              bit_idx <= '0;
              if (GAP_CYCLES > 0) begin
                st      <= S_GAP;
                gap_cnt <= '0;
              end else begin
                st <= S_IDLE;
              end
            end else begin
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
              bit_idx <= bit_idx + 4'd1;
            end
          end
          S_GAP: begin
            // Counter is cleared on exit so it never reaches GAP_CYCLES.
            if (gap_cnt == GAP_LAST) begin
              st      <= S_IDLE;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  assign state    = st;
  assign in_ready = (st == S_IDLE);
  assign frame    = (st == S_SHIFT);
  assign x        = (st == S_SHIFT) ? shreg[WIDTH-1] : IDLE_LEVEL;

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - self-checking bench for serial_word_tx (default and 8-bit/no-gap/idle-high builds)
module tb_serial_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_valid, a_abort;
  logic [11:0] a_data;
  logic        a_ready, a_x, a_frame, a_done;
  logic [3:0]  a_bidx;
  logic [1:0]  a_state;

  logic        b_rst, b_valid, b_abort;
  logic [7:0]  b_data;
  logic        b_ready, b_x, b_frame, b_done;
  logic [3:0]  b_bidx;
  logic [1:0]  b_state;

  serial_word_tx dut_a (
    .CLK(clk), .RESET(a_rst), .in_valid(a_valid), .in_data(a_data), .abort(a_abort),
    .in_ready(a_ready), .x(a_x), .frame(a_frame), .done(a_done), .bit_idx(a_bidx), .state(a_state)
  );

  serial_word_tx #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut_b (
    .CLK(clk), .RESET(b_rst), .in_valid(b_valid), .in_data(b_data), .abort(b_abort),
    .in_ready(b_ready), .x(b_x), .frame(b_frame), .done(b_done), .bit_idx(b_bidx), .state(b_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int a_done_cnt = 0;

  // Reference model: m_ph = cycles elapsed since the accept edge, 0 when idle.
  int          m_ph   [2];
  logic [15:0] m_word [2];
  logic        m_done [2];

  task automatic cmp(input string tag, input int id, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, id, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input int id);
    int w = (id == 0) ? 12 : 8;
    int g = (id == 0) ? 2 : 0;
    logic rst, vld, abt;
    logic [15:0] dat;
    if (id == 0) begin
      rst = a_rst; vld = a_valid; abt = a_abort; dat = {4'h0, a_data};
    end else begin
      rst = b_rst; vld = b_valid; abt = b_abort; dat = {8'h00, b_data};
    end
    if (rst) begin
      m_ph[id] = 0; m_done[id] = 1'b0;
    end else if (abt && m_ph[id] > 0) begin
      m_ph[id] = 0; m_done[id] = 1'b0;
    end else if (m_ph[id] == 0) begin
      m_done[id] = 1'b0;
      if (vld) begin
        m_word[id] = dat;
        m_ph[id] = 1;
      end
    end else begin
      m_done[id] = (m_ph[id] == w);
      m_ph[id]++;
      if (m_ph[id] > w + g) m_ph[id] = 0;
    end
  endtask

  task automatic check(input int id);
    int w = (id == 0) ? 12 : 8;
    logic il = (id == 1);
    int ph = m_ph[id];
    logic fr = (ph >= 1) && (ph <= w);
    logic ex = fr ? m_word[id][w - ph] : il;
    logic [3:0] eb = fr ? 4'(ph - 1) : 4'd0;
    logic [1:0] es = (ph == 0) ? 2'd0 : (fr ? 2'd1 : 2'd2);
    if (id == 0) begin
      cmp("in_ready", 0, {15'd0, a_ready}, {15'd0, ph == 0});
      cmp("x",        0, {15'd0, a_x},     {15'd0, ex});
      cmp("frame",    0, {15'd0, a_frame}, {15'd0, fr});
      cmp("done",     0, {15'd0, a_done},  {15'd0, m_done[0]});
      cmp("bit_idx",  0, {12'd0, a_bidx},  {12'd0, eb});
      cmp("state",    0, {14'd0, a_state}, {14'd0, es});
    end else begin
      cmp("in_ready", 1, {15'd0, b_ready}, {15'd0, ph == 0});
      cmp("x",        1, {15'd0, b_x},     {15'd0, ex});
      cmp("frame",    1, {15'd0, b_frame}, {15'd0, fr});
      cmp("done",     1, {15'd0, b_done},  {15'd0, m_done[1]});
      cmp("bit_idx",  1, {12'd0, b_bidx},  {12'd0, eb});
      cmp("state",    1, {14'd0, b_state}, {14'd0, es});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check(0);
    check(1);
    if (a_done) a_done_cnt++;
  endtask

  task automatic send_a(input logic [11:0] d);
    a_valid = 1'b1; a_data = d;
    step();
    a_valid = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_abort = 1'b0; a_data = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_abort = 1'b0; b_data = '0;
    step();
    a_rst = 1'b0; b_rst = 1'b0;
    step();

    // Single word 12'hA5C
    send_a(12'hA5C);
    repeat (16) step();

    // Back-to-back with valid held: FFF then 001
    a_done_cnt = 0;
    a_valid = 1'b1; a_data = 12'hFFF;
    step();
    a_data = 12'h001;
    repeat (15) step();
    a_valid = 1'b0;
    repeat (16) step();
    cmp("b2b_done_pulses", 0, 16'(a_done_cnt), 16'd2);

    // Ignore in_valid while busy (bit_idx=4 and during gap)
    send_a(12'hABC);
    repeat (4) step();
    a_valid = 1'b1; a_data = 12'h123;
    step();
    a_valid = 1'b0;
    repeat (7) step();
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    repeat (4) step();

    // Abort at bit_idx=5, then immediate new word
    send_a(12'h5A5);
    repeat (5) step();
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    send_a(12'h9C3);
    repeat (15) step();

    // Reset mid-frame at bit_idx=7 together with in_valid
    send_a(12'h7E1);
    repeat (7) step();
    a_rst = 1'b1; a_valid = 1'b1; a_data = 12'h456;
    step();
    a_rst = 1'b0; a_valid = 1'b0;
    repeat (3) step();

    // Abort together with in_valid while idle: word accepted
    a_abort = 1'b1;
    send_a(12'h0F0);
    a_abort = 1'b0;
    repeat (15) step();

    // Narrow build: GAP_CYCLES=0, IDLE_LEVEL=1, data 8'h3C
    b_valid = 1'b1; b_data = 8'h3C;
    step();
    b_valid = 1'b0;
    repeat (10) step();

    // Randomized traffic on both builds
    for (int i = 0; i < 600; i++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      a_data  = 12'($urandom);
      a_abort = ($urandom_range(0, 19) == 0);
      a_rst   = ($urandom_range(0, 79) == 0);
      b_valid = ($urandom_range(0, 2) != 0);
      b_data  = 8'($urandom);
      b_abort = ($urandom_range(0, 15) == 0);
      b_rst   = ($urandom_range(0, 79) == 0);
      step();
    end
    a_valid = 1'b0; a_abort = 1'b0; a_rst = 1'b0;
    b_valid = 1'b0; b_abort = 1'b0; b_rst = 1'b0;
    repeat (16) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
